bus_rr_arbiter: RTL
===================

# bus_rr_arbiter

Parametrised bus arbiter for the bus-driver verification environment: it connects `drvrs` per-device FIFOs to a shared bus. On each transfer it picks one pending source by round-robin or fixed priority, pops one packet, and delivers it to the destination device named in the packet header, or to every other device for a broadcast. It also filters packets it cannot deliver and counts them, which earlier bus drivers did not do. It drops into `test_bench` in place of the earlier bus driver, on the same `dut_compl_if` signal set.

## Interface
- `pckg_sz`, 16: packet width in bits. Must be ≥ `ID_W` + 1.
- `drvrs`, 8: number of devices, 2..255.
- `ID_W`, 8: destination-ID field width, taken from packet bits [pckg_sz-1 -: ID_W].
- `broad`, {ID_W{1'b1}}: broadcast destination ID.
- `PRIO_MODE`, 0: 0 selects round-robin, 1 selects fixed priority (lowest index wins).

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low.
- `pndng`  in  [drvrs]: source FIFO non-empty. `D_pop[i]` is valid whenever `pndng[i]`=1 (show-ahead).
- `D_pop`  in  [drvrs][pckg_sz]: head packet of each source FIFO.
- `pop`  out  [drvrs]: one-cycle pop strobe to a source FIFO.
- `push`  out  [drvrs]: one-cycle write strobe to a destination FIFO.
- `D_push`  out  [drvrs][pckg_sz]: write data for each destination.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `drop_cnt`  out  16: saturating count of dropped packets.

## Operation
- FSM states:
  - IDLE: if any `pndng` bit is 1, the picker selects a grantee `g`, and the block latches `pkt`=`D_pop[g]` and `src`=g, then goes to POP. With no requests it stays in IDLE.
  - POP: `pop[g]`=1 for exactly one cycle; the destination is decoded from `pkt`.
    - If the packet is deliverable, go to PUSH.
    - Otherwise go to IDLE and increment `drop_cnt`.
  - PUSH: one cycle.
    - `push[dest]`=1 for a unicast.
    - For a broadcast, `push[i]`=1 for all i≠src.
    - All lanes of `D_push` carry `pkt`. Then go to IDLE.
- Destination classes:
  - A packet is dropped if `dest`==`src` (self-send), or if `dest` ≥ `drvrs` and `dest`≠`broad`. A dropped packet is still popped.
- Round-robin:
  - The pointer `last` updates to g on entering POP.
  - The search starts at `last`+1 and wraps modulo `drvrs`.
  - `last` resets to `drvrs`-1, so index 0 wins first after reset.
  - When `PRIO_MODE`=1, `last` is ignored.
- `drop_cnt` saturates at 16'hFFFF.
- `pndng` changes while the FSM is in POP or PUSH have no effect; the picker samples only in IDLE.
- Reset values (after `reset`=0 at a clock edge): state IDLE, `pop`=0, `push`=0, `D_push` all 0, `busy`=0, `drop_cnt`=0, `last`=`drvrs`-1.
- Reset mid-operation: the latched packet is discarded and no push is issued. A pop already asserted counts as consumed.

## Timing
- Request sampled at edge k (IDLE) → `pop[g]` high in cycle k+1 → `push` high in cycle k+2.
- Back-to-back requests are sampled at edge k+3, giving a throughput of one packet per 3 cycles; a dropped packet takes 2 cycles.
- All outputs are registered. No combinational path from inputs to outputs.
- `D_push` is zero outside PUSH cycles.

## Structure
- Package `bus_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, POP, PUSH};
  - the ID-field extraction function;
  - the `drop_cnt` width constant.
- Sub-module `rr_picker`, parametrised on `drvrs` and `PRIO_MODE`.
  - Inputs: `pndng`, `last`, `en`.
  - Outputs: one-hot `gnt` and `gnt_idx`.
  - Holds no state of its own; the top level owns `last`.
- Top level holds the FSM, packet/source registers, destination decode, push fan-out and the drop counter.

## Test plan
- Unicast:
  - Stimulus: after reset, `pndng[2]`=1, `D_pop[2]`=16'h05AB.
  - Required: `pop[2]` pulses once; on the next cycle `push[5]`=1 and `D_push[5]`=16'h05AB; `drop_cnt`=0.
- Broadcast:
  - Stimulus: `D_pop[3]`=16'hFF12.
  - Required: `push` = 8'b1111_0111 for one cycle; all lanes of `D_push` = 16'hFF12.
- Round-robin fairness:
  - Stimulus: `pndng`=8'hFF held, all packets valid unicasts.
  - Required: grant order 0,1,…,7,0, one grant every 3 cycles.
  - Rerun with `PRIO_MODE`=1: required grant order 0,0,0,…
- Drops:
  - Stimulus: `D_pop[4]`=16'h0899 (dest 8 ≥ `drvrs`), then `D_pop[1]`=16'h0100 (self-send).
  - Required: both popped, no push, `drop_cnt`=2.
  - Separately, force `drop_cnt` to 16'hFFFF and drop one more packet: required `drop_cnt` holds 16'hFFFF.
- Reset mid-transfer:
  - Stimulus: `reset`=0 asserted during the POP cycle.
  - Required: no push follows; all outputs return to their reset values; after reset release, index 0 is granted first.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding, counter width and header field extraction for the bus arbiter
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE, POP, PUSH} arb_state_t;
  localparam int DROP_W = 16;
  localparam int PKT_MAX_W = 256;
  function automatic logic [31:0] get_id(logic [PKT_MAX_W-1:0] pkt, int psz, int idw);
    return 32'(pkt >> (psz - idw)) & ~(32'hFFFF_FFFF << idw);
  endfunction
endpackage

// File: rtl/bus_rr_arbiter_if.sv
// bus_rr_arbiter_if: source FIFO heads, destination writes and status of the shared bus
interface bus_rr_arbiter_if #(parameter int pckg_sz = 16, parameter int drvrs = 8);
  import bus_arb_pkg::*;
  logic [drvrs-1:0] pndng, pop, push;
  logic [pckg_sz-1:0] D_pop [drvrs];
  logic [pckg_sz-1:0] D_push [drvrs];
  logic busy;
  logic [DROP_W-1:0] drop_cnt;
  modport master(input pndng, D_pop, output pop, push, D_push, busy, drop_cnt);
  modport slave(output pndng, D_pop, input pop, push, D_push, busy, drop_cnt);
endinterface

// File: rtl/bus_rr_arbiter_rr_picker.sv
// rr_picker: stateless round-robin / fixed-priority grant selection starting after last
module rr_picker #(
  parameter int drvrs = 8,
  parameter bit PRIO_MODE = 0,
  localparam int IW = $clog2(drvrs)
)(
  input  logic [drvrs-1:0] pndng,
  input  logic [IW-1:0]    last,
  input  logic             en,
  output logic [drvrs-1:0] gnt,
  output logic [IW-1:0]    gnt_idx
);
  int idx;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    idx = 0;
    for (int k = 0; k < drvrs; k++) begin
      idx = PRIO_MODE ? k : (int'(last) + 1 + k) % drvrs;
      if (en && gnt == '0 && pndng[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: pops one packet per transfer and delivers it unicast or broadcast, counting undeliverable ones
module bus_rr_arbiter import bus_arb_pkg::*; #(
  parameter int pckg_sz = 16,
  parameter int drvrs = 8,
  parameter int ID_W = 8,
  parameter logic [ID_W-1:0] broad = '1,
  parameter bit PRIO_MODE = 0
)(
  input logic clk,
  input logic reset,
  bus_rr_arbiter_if.master bus
);
  localparam int IW = $clog2(drvrs);
  arb_state_t state, state_n;
  logic [pckg_sz-1:0] pkt_q;
  logic [IW-1:0] src_q, last_q, gnt_idx;
  logic [drvrs-1:0] gnt, push_n, push_mask;
  logic [DROP_W-1:0] drop_q;
  logic [31:0] dest;
  logic req, is_broad, drop;
  assign req = |bus.pndng;
  assign dest = get_id(PKT_MAX_W'(pkt_q), pckg_sz, ID_W);
  assign is_broad = dest == 32'(broad);
  assign drop = dest == 32'(src_q) || (dest >= 32'(drvrs) && !is_broad);
  assign push_mask = is_broad ? ~(drvrs'(1) << src_q) : drvrs'(1) << dest;
  assign bus.busy = state != IDLE;
  assign bus.drop_cnt = drop_q;
  rr_picker #(.drvrs(drvrs), .PRIO_MODE(PRIO_MODE)) u_pick (
    .pndng(bus.pndng), .last(last_q), .en(state == IDLE), .gnt(gnt), .gnt_idx(gnt_idx)
  );
  always_comb begin
    state_n = state == IDLE ? (req ? POP : IDLE) : state == POP ? (drop ? IDLE : PUSH) : IDLE;
    push_n = state == POP && !drop ? push_mask : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      bus.pop <= '0;
      bus.push <= '0;
      pkt_q <= '0;
      src_q <= '0;
      last_q <= IW'(drvrs - 1);
      drop_q <= '0;
      for (int i = 0; i < drvrs; i++) bus.D_push[i] <= '0;
    end else begin
      state <= state_n;
      bus.pop <= gnt;
      bus.push <= push_n;
      for (int i = 0; i < drvrs; i++) bus.D_push[i] <= state_n == PUSH ? pkt_q : '0;
      if (state == IDLE && req) begin
        pkt_q <= bus.D_pop[gnt_idx];
        src_q <= gnt_idx;
        last_q <= gnt_idx;
      end
      if (state == POP && drop && drop_q != '1) drop_q <= drop_q + DROP_W'(1);
    end
  end
endmodule
